mgt_01_mp_reg_file: RTL and testbench
=====================================

MGT_01_MP_REG_FILE -- requirements
Module: mgt_01_mp_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count, power of two, at least 2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, read port count.
REQ-004 SHALL have parameter NUM_WR, default 2, write port count.
REQ-005 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: clear_i in 1 request full register clear; ready_o out 1 file usable.
REQ-008 SHALL have ports: we_i in [NUM_WR] write enables; waddr_i in [NUM_WR][AW] write addresses; wdata_i in [NUM_WR][DATA_W] write data.
REQ-009 SHALL have ports: raddr_i in [NUM_RD][AW] read addresses; rdata_o out [NUM_RD][DATA_W] read data; rbusy_o out [NUM_RD] pending-write flag.
REQ-010 SHALL have ports: busy_set_i in 1 mark register pending; busy_addr_i in AW register to mark.

Function
REQ-011 SHALL implement FSM states CLEAR and READY; ready_o is 1 only in READY.
REQ-012 In CLEAR, SHALL write zero to register[cnt] each cycle, incrementing cnt from 0; at cnt = NUM_REGS-1, SHALL go to READY next cycle. Clear takes NUM_REGS cycles.
REQ-013 In READY, clear_i = 1 SHALL cause CLEAR next cycle with cnt = 0. In CLEAR, clear_i = 1 SHALL restart cnt at 0.
REQ-014 In CLEAR, SHALL ignore we_i and busy_set_i; rdata_o SHALL be 0 and rbusy_o SHALL be 0.
REQ-015 In READY, a write SHALL take effect on posedge clk_i when we_i[k] = 1 and waddr_i[k] != 0.
REQ-016 When several ports write the same address in one cycle, the highest port index SHALL win.
REQ-017 Register 0 SHALL always read 0, is never written, and is never busy.
REQ-018 Reads SHALL be combinational: rdata_o[j] = register[raddr_i[j]].
REQ-019 If BYPASS = 1, a read address matching an active same-cycle write SHALL return the winning wdata_i (per REQ-016) in that cycle. If BYPASS = 0, it SHALL return the old value.
REQ-020 In READY, busy_set_i = 1 with busy_addr_i != 0 SHALL set busy[busy_addr_i] on the next edge.
REQ-021 A write to address a SHALL clear busy[a] on the next edge. If busy_set_i targets the same address in the same cycle, set SHALL win.
REQ-022 rbusy_o[j] SHALL equal busy[raddr_i[j]]. If BYPASS = 1, rbusy_o[j] SHALL read 0 when a same-cycle write hits raddr_i[j].
REQ-023 Every read port SHALL be independent; identical addresses on all ports SHALL be legal.

Reset
REQ-024 rst_i SHALL asynchronously force state = CLEAR, cnt = 0, all busy bits 0, and ready_o = 0.
REQ-025 Storage array SHALL NOT be reset directly; it is zeroed by the CLEAR sweep after rst_i deasserts.
REQ-026 rst_i asserted mid-sweep or mid-operation SHALL restart the sweep from cnt = 0.

Structure
REQ-027 data_bus_t, the register-address type, and default DATA_W/NUM_REGS constants SHALL live in the shared modules package.
REQ-028 The write-port priority/merge logic SHALL be one sub-module, mgt_01_wr_arbiter, giving per-address winning enable and data. It SHALL be reused by the bypass path.
REQ-029 Storage SHALL be a flop array without a reset term.

Verification
REQ-030 Pulse rst_i, then release -> ready_o = 0 for 32 cycles, then 1; all reads return 0x00000000.
REQ-031 Port 0 writes x5 = 0x11111111 and port 1 writes x5 = 0x22222222 in the same cycle; read x5 next cycle -> 0x22222222.
REQ-032 BYPASS = 1: write x7 = 0xDEADBEEF while reading x7 in the same cycle -> rdata_o = 0xDEADBEEF that cycle. BYPASS = 0 -> old value.
REQ-033 busy_set_i for x3 -> rbusy_o = 1 for x3. Write x3 -> busy 0. Set and write x3 in the same cycle -> busy stays 1.
REQ-034 Write x0 = 0xFFFFFFFF with busy_set_i on x0 -> x0 reads 0 and rbusy_o = 0.
REQ-035 Load x1..x31 with nonzero values, pulse clear_i, assert rst_i at sweep cycle 10 -> sweep restarts. After 32 cycles, all registers read 0 and ready_o = 1.

Source files
------------

// File: rtl/mgt_01_mp_reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
//   data_bus_t  : one register word at the default width
//   reg_addr_t  : register index at the default register count
//   rf_state_e  : sweep/operational state of the file
package mgt_01_mp_reg_file_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned AW_DEF       = $clog2(NUM_REGS_DEF);

    typedef logic [DATA_W_DEF-1:0] data_bus_t;
    typedef logic [AW_DEF-1:0]     reg_addr_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/mgt_01_wr_arbiter.sv
// Write-port merge: for every register address, reports whether any port
// writes it this cycle and which data wins (highest port index wins).
// Address 0 is never reported as written.
//   we      : per-port write enable (already qualified by the caller)
//   waddr   : per-port write address
//   wdata   : per-port write data
//   hit_c   : per-address winning write enable (combinational)
//   hdata_c : per-address winning write data (combinational)
module mgt_01_wr_arbiter #(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 32,
    parameter  int unsigned NUM_WR   = 2,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][AW-1:0]      waddr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wdata,
    output logic [NUM_REGS-1:0]            hit_c,
    output logic [NUM_REGS-1:0][DATA_W-1:0] hdata_c
);

    // Later ports overwrite earlier ones, giving highest-index priority.
    always_comb begin
        hit_c   = '0;
        hdata_c = '0;
        for (int a = 1; a < NUM_REGS; a++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && (waddr[k] == AW'(a))) begin
                    hit_c[a]   = 1'b1;
                    hdata_c[a] = wdata[k];
                end
            end
        end
    end

endmodule

// File: rtl/mgt_01_mp_reg_file.sv
// Multi-port register file with zero-sweep initialisation, per-register
// pending-write (busy) flags and optional write-to-read forwarding.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : request a full zero sweep
//   ready_o      : file usable (sweep finished)
//   we_i/waddr_i/wdata_i : write ports
//   raddr_i/rdata_o/rbusy_o : combinational read ports with busy flag
//   busy_set_i/busy_addr_i  : mark a register as pending a write
module mgt_01_mp_reg_file
    import mgt_01_mp_reg_file_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned NUM_WR   = 2,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    output logic                           ready_o,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR-1:0][AW-1:0]      waddr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wdata_i,
    input  logic [NUM_RD-1:0][AW-1:0]      raddr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rdata_o,
    output logic [NUM_RD-1:0]              rbusy_o,
    input  logic                           busy_set_i,
    input  logic [AW-1:0]                  busy_addr_i
);

    rf_state_e                    state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [NUM_REGS-1:0]          busy_q;
    logic [DATA_W-1:0]            regs_q [NUM_REGS];
    logic [NUM_WR-1:0]            we_q_c;
    logic [NUM_REGS-1:0]          hit_c;
    logic [NUM_REGS-1:0][DATA_W-1:0] hdata_c;

    assign ready_o = (state_q == ST_READY);

    // Writes are ignored outright while sweeping.
    assign we_q_c = ready_o ? we_i : '0;

    mgt_01_wr_arbiter #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_wr_arbiter (
        .we      (we_q_c),
        .waddr   (waddr_i),
        .wdata   (wdata_i),
        .hit_c   (hit_c),
        .hdata_c (hdata_c)
    );

    // State and sweep counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep sequencing: NUM_REGS cycles of CLEAR, clear_i restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int a = 1; a < NUM_REGS; a++) begin
                if (hit_c[a]) begin
                    regs_q[a] <= hdata_c[a];
                end
            end
        end
    end

    // Busy flags: a same-cycle set beats the clearing write; a sweep drops all.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else if (state_q != ST_READY) begin
            busy_q <= '0;
        end else begin
            for (int a = 1; a < NUM_REGS; a++) begin
                if (busy_set_i && (busy_addr_i == AW'(a))) begin
                    busy_q[a] <= 1'b1;
                end else if (hit_c[a]) begin
                    busy_q[a] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports; forwarded data reports not-busy.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (ready_o && (raddr_i[j] != '0)) begin
                if ((BYPASS != 0) && hit_c[raddr_i[j]]) begin
                    rdata_o[j] = hdata_c[raddr_i[j]];
                end else begin
                    rdata_o[j] = regs_q[raddr_i[j]];
                    rbusy_o[j] = busy_q[raddr_i[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_mp_reg_file.sv
// Bench for the multi-port register file: a forwarding and a non-forwarding
// instance share all inputs; directed scenarios plus random traffic checked
// against a behavioural model of registers, busy flags and the sweep.
module tb_mgt_01_mp_reg_file;
    import mgt_01_mp_reg_file_pkg::*;

    localparam int unsigned NR  = 32;
    localparam int unsigned NRD = 2;
    localparam int unsigned NWR = 2;
    localparam int unsigned AW  = 5;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                     rst_i;
    logic                     clear_i;
    logic [NWR-1:0]           we_i;
    logic [NWR-1:0][AW-1:0]   waddr_i;
    logic [NWR-1:0][31:0]     wdata_i;
    logic [NRD-1:0][AW-1:0]   raddr_i;
    logic                     busy_set_i;
    logic [AW-1:0]            busy_addr_i;

    logic                     ready_b, ready_n;
    logic [NRD-1:0][31:0]     rdata_b, rdata_n;
    logic [NRD-1:0]           rbusy_b, rbusy_n;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    mgt_01_mp_reg_file #(.BYPASS(1)) u_dut_byp (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_b),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i)
    );

    mgt_01_mp_reg_file #(.BYPASS(0)) u_dut_nobyp (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_n),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i)
    );

    // Behavioural model
    data_bus_t m_mem [NR];
    bit        m_busy[NR];
    bit        m_ready;
    int        m_cnt;

    // Winning same-cycle write to address a, if any (last enabled port wins).
    function automatic bit win(input int a, output data_bus_t d);
        win = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] && int'(waddr_i[k]) == a) begin
                    win = 1'b1;
                    d   = wdata_i[k];
                end
            end
        end
    endfunction

    function automatic data_bus_t exp_rdata(input int j, input bit byp);
        int a;
        data_bus_t d;
        a = int'(raddr_i[j]);
        if (!m_ready || a == 0) return '0;
        if (byp && win(a, d)) return d;
        return m_mem[a];
    endfunction

    function automatic bit exp_rbusy(input int j, input bit byp);
        int a;
        data_bus_t d;
        a = int'(raddr_i[j]);
        if (!m_ready || a == 0) return 1'b0;
        if (byp && win(a, d)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
        for (int a = 0; a < NR; a++) m_busy[a] = 1'b0;
    endtask

    task automatic model_clock();
        data_bus_t d;
        if (!m_ready) begin
            m_mem[m_cnt] = '0;
            for (int a = 0; a < NR; a++) m_busy[a] = 1'b0;
            if (clear_i) m_cnt = 0;
            else if (m_cnt == NR - 1) begin m_ready = 1'b1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end else begin
            for (int a = 1; a < NR; a++) begin
                if (win(a, d)) begin m_mem[a] = d; m_busy[a] = 1'b0; end
                if (busy_set_i && int'(busy_addr_i) == a) m_busy[a] = 1'b1;
            end
            if (clear_i) begin m_ready = 1'b0; m_cnt = 0; end
        end
    endtask

    // One clock: model follows the edge, returns at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
    endtask

    task automatic idle();
        we_i       = '0;
        clear_i    = 1'b0;
        busy_set_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        #2;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        raddr_i = {5'd9, 5'd4};
        do_reset();
        for (int i = 0; i < 32; i++) begin
            #1;
            vectors++;
            if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ready_low cyc %0d: got %b/%b want 0/0", i, ready_b, ready_n);
            end
            vectors++;
            if (rdata_b[0] !== 32'h0 || rbusy_b[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read_in_clear cyc %0d: got %h/%b want 0/0", i, rdata_b[0], rbusy_b[0]);
            end
            tick();
        end
        #1;
        vectors++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_high: got %b/%b want 1/1", ready_b, ready_n);
        end
        for (int a = 0; a < 32; a++) begin
            raddr_i = {AW'(31 - a), AW'(a)};
            #1;
            vectors++;
            if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || rbusy_b !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_all_zero addr %0d: got %h %h want 0", a, rdata_b, rdata_n);
            end
            tick();
        end
    endtask

    task automatic test_same_addr();
        idle();
        we_i       = 2'b11;
        waddr_i    = {5'd5, 5'd5};
        wdata_i[0] = 32'h11111111;
        wdata_i[1] = 32'h22222222;
        raddr_i    = {5'd5, 5'd5};
        #1;
        vectors++;
        if (rdata_b[0] !== 32'h22222222 || rdata_n[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL same_addr_fwd: got %h/%h want 22222222/00000000", rdata_b[0], rdata_n[0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rdata_b[1] !== 32'h22222222 || rdata_n[1] !== 32'h22222222) begin
            miscompares++;
            $display("FAIL same_addr_prio: got %h/%h want 22222222", rdata_b[1], rdata_n[1]);
        end
    endtask

    task automatic test_bypass();
        idle();
        we_i       = 2'b01;
        waddr_i[0] = 5'd7;
        wdata_i[0] = 32'h12345678;
        tick();
        wdata_i[0] = 32'hDEADBEEF;
        raddr_i[1] = 5'd7;
        #1;
        vectors++;
        if (rdata_b[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_on: got %h want deadbeef", rdata_b[1]);
        end
        vectors++;
        if (rdata_n[1] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_off: got %h want 12345678", rdata_n[1]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rdata_b[1] !== 32'hDEADBEEF || rdata_n[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_commit: got %h/%h want deadbeef", rdata_b[1], rdata_n[1]);
        end
    endtask

    task automatic test_busy();
        idle();
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd3;
        raddr_i     = {5'd3, 5'd3};
        tick();
        idle();
        #1;
        vectors++;
        if (rbusy_b !== 2'b11 || rbusy_n !== 2'b11) begin
            miscompares++;
            $display("FAIL busy_set: got %b/%b want 11/11", rbusy_b, rbusy_n);
        end
        we_i       = 2'b01;
        waddr_i[0] = 5'd3;
        wdata_i[0] = 32'h000000A5;
        #1;
        vectors++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1 || rdata_b[0] !== 32'hA5) begin
            miscompares++;
            $display("FAIL busy_fwd: got %b/%b/%h want 0/1/000000a5", rbusy_b[0], rbusy_n[0], rdata_b[0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_clear_by_write: got %b/%b want 0/0", rbusy_b[0], rbusy_n[0]);
        end
        we_i        = 2'b10;
        waddr_i[1]  = 5'd3;
        wdata_i[1]  = 32'h0000005A;
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd3;
        tick();
        idle();
        #1;
        vectors++;
        if (rbusy_b[1] !== 1'b1 || rbusy_n[1] !== 1'b1 || rdata_n[1] !== 32'h5A) begin
            miscompares++;
            $display("FAIL busy_set_wins: got %b/%b/%h want 1/1/0000005a", rbusy_b[1], rbusy_n[1], rdata_n[1]);
        end
    endtask

    task automatic test_x0();
        idle();
        we_i        = 2'b11;
        waddr_i     = {5'd0, 5'd0};
        wdata_i     = {32'hFFFFFFFF, 32'hFFFFFFFF};
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd0;
        raddr_i     = {5'd0, 5'd0};
        #1;
        vectors++;
        if (rdata_b[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_no_fwd: got %h want 0", rdata_b[0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || rbusy_b !== 2'b00 || rbusy_n !== 2'b00) begin
            miscompares++;
            $display("FAIL x0_zero: got %h %h %b %b want 0", rdata_b, rdata_n, rbusy_b, rbusy_n);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we_i        = NWR'($urandom);
            busy_set_i  = ($urandom_range(0, 2) == 0);
            busy_addr_i = AW'($urandom_range(0, 7));
            clear_i     = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NWR; k++) begin
                waddr_i[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                wdata_i[k] = $urandom;
            end
            for (int j = 0; j < NRD; j++)
                raddr_i[j] = ($urandom_range(0, 2) == 0) ? waddr_i[$urandom_range(0, 1)]
                                                         : AW'($urandom_range(0, 7));
            #1;
            vectors++;
            if (ready_b !== m_ready || ready_n !== m_ready) begin
                miscompares++;
                $display("FAIL rand_ready cyc %0d: got %b/%b want %b", c, ready_b, ready_n, m_ready);
            end
            for (int j = 0; j < NRD; j++) begin
                vectors++;
                if (rdata_b[j] !== exp_rdata(j, 1'b1) || rbusy_b[j] !== exp_rbusy(j, 1'b1)) begin
                    miscompares++;
                    $display("FAIL rand_byp cyc %0d port %0d addr %0d: got %h/%b want %h/%b", c, j,
                             raddr_i[j], rdata_b[j], rbusy_b[j], exp_rdata(j, 1'b1), exp_rbusy(j, 1'b1));
                end
                vectors++;
                if (rdata_n[j] !== exp_rdata(j, 1'b0) || rbusy_n[j] !== exp_rbusy(j, 1'b0)) begin
                    miscompares++;
                    $display("FAIL rand_nobyp cyc %0d port %0d addr %0d: got %h/%b want %h/%b", c, j,
                             raddr_i[j], rdata_n[j], rbusy_n[j], exp_rdata(j, 1'b0), exp_rbusy(j, 1'b0));
                end
            end
            tick();
        end
        idle();
        // Let any sweep started by random clear_i finish.
        for (int i = 0; i < 40; i++) tick();
    endtask

    task automatic test_clear_reset();
        idle();
        for (int a = 1; a < 32; a++) begin
            we_i       = 2'b01;
            waddr_i[0] = AW'(a);
            wdata_i[0] = $urandom | 32'h1;
            tick();
        end
        idle();
        for (int a = 1; a < 32; a += 15) begin
            raddr_i[0] = AW'(a);
            #1;
            vectors++;
            if (rdata_b[0] !== m_mem[a] || rdata_b[0] === 32'h0) begin
                miscompares++;
                $display("FAIL load_nonzero addr %0d: got %h want %h", a, rdata_b[0], m_mem[a]);
            end
            tick();
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            #1;
            vectors++;
            if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_ready_low cyc %0d: got %b/%b want 0/0", i, ready_b, ready_n);
            end
            tick();
        end
        #1;
        vectors++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_ready_high: got %b/%b want 1/1", ready_b, ready_n);
        end
        for (int a = 0; a < 32; a++) begin
            raddr_i = {AW'(a), AW'(a)};
            #1;
            vectors++;
            if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
                miscompares++;
                $display("FAIL restart_zero addr %0d: got %h %h want 0", a, rdata_b, rdata_n);
            end
            tick();
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        we_i        = '0;
        waddr_i     = '0;
        wdata_i     = '0;
        raddr_i     = '0;
        busy_set_i  = 1'b0;
        busy_addr_i = '0;
        for (int a = 0; a < NR; a++) m_mem[a] = '0;
        model_reset();
        test_reset();
        test_same_addr();
        test_bypass();
        test_busy();
        test_x0();
        test_random();
        test_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
